mips_mc_control: RTL and testbench

//  Multi-cycle main control FSM for the MIPS core: the driving end of the datapath control interface.

---
 rtl/mips_mc_control_pkg.sv | 58 +++++
 rtl/mips_mc_opdecode.sv | 43 ++++
 rtl/mips_mc_control.sv | 154 +++++++++++++++
 tb/tb_mips_mc_control.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/mips_mc_control_pkg.sv
// Shared definitions for the multi-cycle MIPS control FSM: opcodes, datapath select encodings,
// state encodings and the bundled control word.
package mips_mc_control_pkg;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [1:0] AluOpAdd   = 2'd0;
  localparam logic [1:0] AluOpSub   = 2'd1;
  localparam logic [1:0] AluOpFunct = 2'd2;

  localparam logic [1:0] SrcBReg   = 2'd0;
  localparam logic [1:0] SrcBFour  = 2'd1;
  localparam logic [1:0] SrcBImm   = 2'd2;
  localparam logic [1:0] SrcBImmSh = 2'd3;

  localparam logic [1:0] PcSrcAlu    = 2'd0;
  localparam logic [1:0] PcSrcAluOut = 2'd1;
  localparam logic [1:0] PcSrcJump   = 2'd2;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StRwb    = 4'd7,
    StBeq    = 4'd8,
    StAddiEx = 4'd9,
    StAddiWb = 4'd10,
    StJump   = 4'd11,
    StHalt   = 4'd12
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
  } ctrl_t;

endpackage

// File: rtl/mips_mc_opdecode.sv
// Combinational opcode decode: DECODE-state successor and illegal-opcode flag.
// Opcode 0x02 is legal only when MIPS_MC_JUMP_EN is defined.
module mips_mc_opdecode
  import mips_mc_control_pkg::*;
#(
  parameter bit ILLEGAL_TRAP = 1'b0
) (
  input  logic [5:0] opcode_i,
  output state_t     next_state_o,
  output logic       illegal_o
);

  always_comb begin
    next_state_o = ILLEGAL_TRAP ? StHalt : StFetch;
    illegal_o    = 1'b1;
    case (opcode_i)
      OpLw, OpSw: begin
        next_state_o = StMemAdr;
        illegal_o    = 1'b0;
      end
      OpRtype: begin
        next_state_o = StExec;
        illegal_o    = 1'b0;
      end
      OpBeq: begin
        next_state_o = StBeq;
        illegal_o    = 1'b0;
      end
      OpAddi: begin
        next_state_o = StAddiEx;
        illegal_o    = 1'b0;
      end
`ifdef MIPS_MC_JUMP_EN
      OpJ: begin
        next_state_o = StJump;
        illegal_o    = 1'b0;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS main control FSM driving all datapath selects and enables.
// Optional jump support is enabled by defining MIPS_MC_JUMP_EN.
module mips_mc_control
  import mips_mc_control_pkg::*;
#(
  parameter bit ILLEGAL_TRAP = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OpCode,
  input  logic       Zero,
  output logic       PCEn,
  output logic       PCWrite,
  output logic       Branch,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       instr_done,
  output logic       illegal_op
);

  state_t state_q, state_d;
  state_t decode_next;
  logic   decode_illegal;
  ctrl_t  ctrl;

  mips_mc_opdecode #(
    .ILLEGAL_TRAP (ILLEGAL_TRAP)
  ) u_opdecode (
    .opcode_i     (OpCode),
    .next_state_o (decode_next),
    .illegal_o    (decode_illegal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Unlisted encodings (including JUMP when disabled) fall back to FETCH.
  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch:  state_d = StDecode;
      StDecode: state_d = decode_next;
      StMemAdr: state_d = (OpCode == OpLw) ? StMemRd : StMemWr;
      StMemRd:  state_d = StMemWb;
      StExec:   state_d = StRwb;
      StAddiEx: state_d = StAddiWb;
      StHalt:   state_d = StHalt;
      default:  state_d = StFetch;
    endcase
  end

  always_comb begin
    ctrl = '0;
    case (state_q)
      StFetch: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.alu_src_b = SrcBFour;
        ctrl.alu_op    = AluOpAdd;
        ctrl.pc_source = PcSrcAlu;
        ctrl.pc_write  = 1'b1;
      end
      StDecode: begin
        ctrl.alu_src_b = SrcBImmSh;
        ctrl.alu_op    = AluOpAdd;
      end
      StMemAdr, StAddiEx: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SrcBImm;
        ctrl.alu_op    = AluOpAdd;
      end
      StMemRd: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      StMemWb: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      StMemWr: begin
        ctrl.mem_write  = 1'b1;
        ctrl.i_or_d     = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      StExec: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SrcBReg;
        ctrl.alu_op    = AluOpFunct;
      end
      StRwb: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      StBeq: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = SrcBReg;
        ctrl.alu_op     = AluOpSub;
        ctrl.branch     = 1'b1;
        ctrl.pc_source  = PcSrcAluOut;
        ctrl.instr_done = 1'b1;
      end
      StAddiWb: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
`ifdef MIPS_MC_JUMP_EN
      StJump: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PcSrcJump;
        ctrl.instr_done = 1'b1;
      end
`endif
      default: ctrl = '0;
    endcase
    // Reset can land mid-instruction; suppress every enable during the reset cycle itself.
    if (reset) begin
      ctrl = '0;
    end
  end

  assign PCWrite    = ctrl.pc_write;
  assign Branch     = ctrl.branch;
  assign IorD       = ctrl.i_or_d;
  assign MemRead    = ctrl.mem_read;
  assign MemWrite   = ctrl.mem_write;
  assign IRWrite    = ctrl.ir_write;
  assign MemtoReg   = ctrl.mem_to_reg;
  assign RegDst     = ctrl.reg_dst;
  assign RegWrite   = ctrl.reg_write;
  assign ALUSrcA    = ctrl.alu_src_a;
  assign ALUSrcB    = ctrl.alu_src_b;
  assign ALUOp      = ctrl.alu_op;
  assign PCSource   = ctrl.pc_source;
  assign instr_done = ctrl.instr_done;
  assign PCEn       = ctrl.pc_write | (ctrl.branch & Zero);
  assign illegal_op = (state_q == StDecode) && decode_illegal && !reset;

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed bench for mips_mc_control; a second instance runs with ILLEGAL_TRAP=1.
module tb_mips_mc_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] OpCode;
  logic       Zero;

  logic       PCEn, PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst;
  logic       RegWrite, ALUSrcA, instr_done, illegal_op;
  logic [1:0] ALUSrcB, ALUOp, PCSource;

  logic       t_PCEn, t_PCWrite, t_Branch, t_IorD, t_MemRead, t_MemWrite, t_IRWrite, t_MemtoReg;
  logic       t_RegDst, t_RegWrite, t_ALUSrcA, t_instr_done, t_illegal_op;
  logic [1:0] t_ALUSrcB, t_ALUOp, t_PCSource;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mips_mc_control #(.ILLEGAL_TRAP(1'b0)) dut (
    .clk(clk), .reset(reset), .OpCode(OpCode), .Zero(Zero), .PCEn(PCEn), .PCWrite(PCWrite),
    .Branch(Branch), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource), .instr_done(instr_done),
    .illegal_op(illegal_op)
  );

  mips_mc_control #(.ILLEGAL_TRAP(1'b1)) dut_trap (
    .clk(clk), .reset(reset), .OpCode(OpCode), .Zero(Zero), .PCEn(t_PCEn), .PCWrite(t_PCWrite),
    .Branch(t_Branch), .IorD(t_IorD), .MemRead(t_MemRead), .MemWrite(t_MemWrite),
    .IRWrite(t_IRWrite), .MemtoReg(t_MemtoReg), .RegDst(t_RegDst), .RegWrite(t_RegWrite),
    .ALUSrcA(t_ALUSrcA), .ALUSrcB(t_ALUSrcB), .ALUOp(t_ALUOp), .PCSource(t_PCSource),
    .instr_done(t_instr_done), .illegal_op(t_illegal_op)
  );

  // {PCWrite,Branch,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,ALUSrcA,
  //  ALUSrcB,ALUOp,PCSource,instr_done,illegal_op}
  logic [17:0] obs, t_obs;
  assign obs = {PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
                ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done, illegal_op};
  assign t_obs = {t_PCWrite, t_Branch, t_IorD, t_MemRead, t_MemWrite, t_IRWrite, t_MemtoReg,
                  t_RegDst, t_RegWrite, t_ALUSrcA, t_ALUSrcB, t_ALUOp, t_PCSource, t_instr_done,
                  t_illegal_op};

  // Expected control words per state, written out by hand.
  localparam logic [17:0] EFetch  = 18'b1_0_0_1_0_1_0_0_0_0_01_00_00_0_0;
  localparam logic [17:0] EDecode = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
  localparam logic [17:0] EDecIll = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_1;
  localparam logic [17:0] EMemAdr = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [17:0] EMemRd  = 18'b0_0_1_1_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] EMemWb  = 18'b0_0_0_0_0_0_1_0_1_0_00_00_00_1_0;
  localparam logic [17:0] EMemWr  = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_1_0;
  localparam logic [17:0] EExec   = 18'b0_0_0_0_0_0_0_0_0_1_00_10_00_0_0;
  localparam logic [17:0] ERwb    = 18'b0_0_0_0_0_0_0_1_1_0_00_00_00_1_0;
  localparam logic [17:0] EBeq    = 18'b0_1_0_0_0_0_0_0_0_1_00_01_01_1_0;
  localparam logic [17:0] EAddiWb = 18'b0_0_0_0_0_0_0_0_1_0_00_00_00_1_0;
  localparam logic [17:0] EJump   = 18'b1_0_0_0_0_0_0_0_0_0_00_00_10_1_0;
  localparam logic [17:0] EZero   = 18'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #3;
  endtask

  // Hold reset 3 cycles with the opcode applied; returns sampling inside cycle 1 (FETCH).
  task automatic start_instr(input logic [5:0] op, input logic z);
    reset  = 1'b1;
    OpCode = op;
    Zero   = z;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1;
  endtask

  // Check cycles 1..n against e[0..n-1], then cycle n+1 must be FETCH again.
  task automatic run_instr(input string tag, input logic [5:0] op, input logic z, input int n,
                           input logic [17:0] e0, input logic [17:0] e1, input logic [17:0] e2,
                           input logic [17:0] e3, input logic [17:0] e4);
    logic [17:0] e [5];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3; e[4] = e4;
    start_instr(op, z);
    for (int i = 0; i < n; i++) begin
      if (i > 0) next_cycle();
      check($sformatf("%s_ctrl_c%0d", tag, i + 1), 32'(obs), 32'(e[i]));
      check($sformatf("%s_pcen_c%0d", tag, i + 1), 32'(PCEn), 32'(e[i][17] | (e[i][16] & z)));
    end
    next_cycle();
    check($sformatf("%s_refetch", tag), 32'(obs), 32'(EFetch));
  endtask

  initial begin
    reset  = 1'b1;
    OpCode = 6'h00;
    Zero   = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    check("reset_ctrl", 32'(obs), 32'(EZero));
    check("reset_pcen", 32'(PCEn), 32'd0);

    run_instr("lw",     6'h23, 1'b0, 5, EFetch, EDecode, EMemAdr, EMemRd, EMemWb);
    run_instr("sw",     6'h2B, 1'b0, 4, EFetch, EDecode, EMemAdr, EMemWr, EZero);
    run_instr("beq_z1", 6'h04, 1'b1, 3, EFetch, EDecode, EBeq, EZero, EZero);
    run_instr("beq_z0", 6'h04, 1'b0, 3, EFetch, EDecode, EBeq, EZero, EZero);
    run_instr("rtype",  6'h00, 1'b0, 4, EFetch, EDecode, EExec, ERwb, EZero);
    run_instr("addi",   6'h08, 1'b0, 4, EFetch, EDecode, EMemAdr, EAddiWb, EZero);
    // Illegal opcode, non-trapping instance returns to FETCH at cycle 3.
    run_instr("ill",    6'h3F, 1'b0, 2, EFetch, EDecIll, EZero, EZero, EZero);
`ifdef MIPS_MC_JUMP_EN
    run_instr("jump",   6'h02, 1'b0, 3, EFetch, EDecode, EJump, EZero, EZero);
`else
    run_instr("j_ill",  6'h02, 1'b0, 2, EFetch, EDecIll, EZero, EZero, EZero);
`endif

    // Trapping instance: pulse in DECODE then silent HALT until reset.
    start_instr(6'h3F, 1'b1);
    next_cycle();
    check("trap_illegal_c2", 32'(t_illegal_op), 32'd1);
    for (int i = 3; i <= 22; i++) begin
      next_cycle();
      check($sformatf("trap_halt_ctrl_c%0d", i), 32'(t_obs), 32'(EZero));
      check($sformatf("trap_halt_pcen_c%0d", i), 32'(t_PCEn), 32'd0);
    end
    start_instr(6'h23, 1'b0);
    check("trap_after_reset", 32'(t_obs), 32'(EFetch));

    // Reset during MEMRD of lw abandons the load.
    next_cycle(); next_cycle(); next_cycle();
    check("mid_memrd", 32'(obs), 32'(EMemRd));
    reset = 1'b1;
    #1;
    check("mid_reset_ctrl", 32'(obs), 32'(EZero));
    check("mid_reset_regwrite", 32'(RegWrite), 32'd0);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("mid_release_irwrite", 32'(IRWrite), 32'd1);
    check("mid_release_regwrite", 32'(RegWrite), 32'd0);
    check("mid_release_ctrl", 32'(obs), 32'(EFetch));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
